// File: rtl/threedeeo_pkg.sv
// threedeeo_pkg: shared defaults, FSM encoding and counter sizing
// for the daisy-chained 3DO controller-port emulator.
package threedeeo_pkg;

   localparam int PAD_BITS_DEFAULT = 16;
   localparam int MAX_PADS         = 8;

   typedef enum logic [1:0] {
      ST_LATCH = 2'd0,
      ST_SHIFT = 2'd1,
      ST_TAIL  = 2'd2
   } state_t;

   // Counter width able to hold 0..total inclusive
   function automatic int cnt_width(input int total);
      return $clog2(total + 1);
   endfunction

endpackage

// File: rtl/threedeeo_chain_sync_edge.sv
// sync_edge: multi-flop synchronizer for one asynchronous console pin,
// with rise/fall pulses derived from the synchronized level.
module sync_edge
   import threedeeo_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic system_clock,
   input  logic system_reset_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge system_clock or negedge system_reset_n) begin
      if (!system_reset_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], d};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign q    = r_sync[SYNC_STAGES-1];
   assign rise = q & ~r_prev;
   assign fall = ~q & r_prev;

endmodule

// File: rtl/threedeeo_chain.sv
// threedeeo_chain: serves NUM_PADS virtual pads as one daisy-chained
// 3DO serial stream, optionally forwarding a physical downstream chain.
module threedeeo_chain
   import threedeeo_pkg::*;
#(
   parameter int NUM_PADS    = 2,
   parameter int PAD_BITS    = PAD_BITS_DEFAULT,
   parameter int SYNC_STAGES = 2,
   parameter int PASSTHRU    = 1
) (
   input  logic                         system_clock,
   input  logic                         system_reset_n,
   input  logic                         clk,
   input  logic                         ps,
   input  logic                         dat_in,
   input  logic [NUM_PADS*PAD_BITS-1:0] i,
   input  logic [NUM_PADS-1:0]          pad_present,
   output logic                         dat,
   output logic                         busy,
   output logic                         frame_done
);

   localparam int TOT = NUM_PADS * PAD_BITS;
   localparam int CW  = cnt_width(TOT);

   logic w_clk_rise, w_clk_fall, w_clk_s;
   logic w_ps_s, w_ps_rise, w_ps_fall;
   logic w_din_s, w_din_rise, w_din_fall;
   logic w_unused;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
      .system_clock  (system_clock),
      .system_reset_n(system_reset_n),
      .d             (clk),
      .q             (w_clk_s),
      .rise          (w_clk_rise),
      .fall          (w_clk_fall)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ps (
      .system_clock  (system_clock),
      .system_reset_n(system_reset_n),
      .d             (ps),
      .q             (w_ps_s),
      .rise          (w_ps_rise),
      .fall          (w_ps_fall)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
      .system_clock  (system_clock),
      .system_reset_n(system_reset_n),
      .d             (dat_in),
      .q             (w_din_s),
      .rise          (w_din_rise),
      .fall          (w_din_fall)
   );

   // ps is acted on as a level, so its rise pulse is redundant
   assign w_unused = ^{w_clk_s, w_clk_fall, w_ps_rise,
                       w_din_rise, w_din_fall};

   logic [PAD_BITS-1:0] w_word [NUM_PADS];
   logic [TOT-1:0]      w_pack;
   logic [CW-1:0]       w_valid;

   for (genvar g = 0; g < NUM_PADS; g++) begin : g_word
      assign w_word[g] = i[TOT-1-g*PAD_BITS -: PAD_BITS];
   end

   // w_valid doubles as the running offset from the MSB
   always_comb begin
      w_pack  = '0;
      w_valid = '0;
      for (int p = 0; p < NUM_PADS; p++) begin
         if (pad_present[p]) begin
            w_pack  = w_pack |
                      ((TOT'(w_word[p]) << (TOT - PAD_BITS)) >> w_valid);
            w_valid = w_valid + CW'(PAD_BITS);
         end
      end
   end

   state_t         r_state, w_state_n;
   logic [TOT-1:0] r_shift, w_shift_n;
   logic [CW-1:0]  r_cnt, w_cnt_n;
   logic [CW-1:0]  r_valid, w_valid_n;
   logic           r_dat, w_dat_n;
   logic           r_done, w_done_n;

   always_ff @(posedge system_clock or negedge system_reset_n) begin
      if (!system_reset_n) begin
         r_state <= ST_LATCH;
         r_shift <= '0;
         r_cnt   <= '0;
         r_valid <= '0;
         r_dat   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_shift <= w_shift_n;
         r_cnt   <= w_cnt_n;
         r_valid <= w_valid_n;
         r_dat   <= w_dat_n;
         r_done  <= w_done_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_shift_n = r_shift;
      w_cnt_n   = r_cnt;
      w_valid_n = r_valid;
      w_done_n  = 1'b0;
      if (w_ps_s || r_state == ST_LATCH) begin
         w_shift_n = w_pack;
         w_cnt_n   = '0;
         w_valid_n = w_valid;
      end
      if (w_ps_s) begin
         w_state_n = ST_LATCH;
      end else begin
         unique case (r_state)
            ST_LATCH: begin
               if (w_ps_fall)
                  w_state_n = (w_valid == '0) ? ST_TAIL : ST_SHIFT;
            end
            ST_SHIFT: begin
               if (w_clk_rise) begin
                  w_shift_n = r_shift << 1;
                  w_cnt_n   = r_cnt + 1'b1;
                  if (w_cnt_n == r_valid) begin
                     w_state_n = ST_TAIL;
                     w_done_n  = 1'b1;
                  end
               end
            end
            ST_TAIL: begin
               w_state_n = ST_TAIL;
            end
            default: begin
               w_state_n = ST_LATCH;
            end
         endcase
      end
   end

   always_comb begin
      w_dat_n = r_shift[TOT-1];
      if (r_state == ST_TAIL)
         w_dat_n = (PASSTHRU != 0) && w_din_s;
   end

   assign dat        = r_dat;
   assign busy       = (r_state == ST_SHIFT);
   assign frame_done = r_done;

endmodule

// File: tb/tb_threedeeo_chain.sv
// tb_threedeeo_chain: vector table, hand-written corner sequences and
// randomized frames against a bit-queue reference model.
module tb_threedeeo_chain;

   logic        sysclk  = 1'b0;
   logic        rst_n   = 1'b0;
   logic        con_clk = 1'b0;
   logic        con_ps  = 1'b0;
   logic        din     = 1'b0;
   logic [31:0] i_a     = '0;
   logic [1:0]  pp_a    = '0;
   logic [15:0] i_b     = '0;
   logic [0:0]  pp_b    = '0;
   logic        dat_a, busy_a, done_a;
   logic        dat_b, busy_b, done_b;

   int n_pass = 0;
   int n_tot  = 0;
   int done_cnt_a = 0;
   int done_cnt_b = 0;

   always #25 sysclk = ~sysclk;

   threedeeo_chain #(
      .NUM_PADS(2), .PAD_BITS(16), .SYNC_STAGES(2), .PASSTHRU(1)
   ) u_a (
      .system_clock(sysclk), .system_reset_n(rst_n),
      .clk(con_clk), .ps(con_ps), .dat_in(din),
      .i(i_a), .pad_present(pp_a),
      .dat(dat_a), .busy(busy_a), .frame_done(done_a)
   );

   threedeeo_chain #(
      .NUM_PADS(1), .PAD_BITS(16), .SYNC_STAGES(2), .PASSTHRU(0)
   ) u_b (
      .system_clock(sysclk), .system_reset_n(rst_n),
      .clk(con_clk), .ps(con_ps), .dat_in(din),
      .i(i_b), .pad_present(pp_b),
      .dat(dat_b), .busy(busy_b), .frame_done(done_b)
   );

   always @(posedge sysclk) begin
      if (done_a) done_cnt_a <= done_cnt_a + 1;
      if (done_b) done_cnt_b <= done_cnt_b + 1;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge sysclk);
   endtask

   task automatic set_ps(input logic v);
      con_ps = v;
      tick(8);
   endtask

   task automatic pulse();
      con_clk = 1'b1;
      tick(8);
      con_clk = 1'b0;
      tick(8);
   endtask

   // Reference model: the frame is the list of bits the console should see
   logic m_bits[$];
   int   m_k;
   bit   m_latched;
   int   m_exp_done;

   function automatic void m_build();
      logic [15:0] w;
      m_bits.delete();
      for (int p = 0; p < 2; p++) begin
         if (pp_a[p]) begin
            w = (p == 0) ? i_a[31:16] : i_a[15:0];
            for (int b = 15; b >= 0; b--) m_bits.push_back(w[b]);
         end
      end
   endfunction

   function automatic logic m_dat();
      if (m_latched) return (m_bits.size() > 0) ? m_bits[0] : 1'b0;
      if (m_k < m_bits.size()) return m_bits[m_k];
      return din;
   endfunction

   function automatic logic m_busy();
      return !m_latched && (m_k < m_bits.size());
   endfunction

   task automatic m_check(input string tag);
      chk({tag, "_dat"}, dat_a, m_dat());
      chk({tag, "_busy"}, busy_a, m_busy());
   endtask

   task automatic m_run(input int n, input string tag);
      int d0;
      d0 = done_cnt_a;
      m_exp_done = 0;
      for (int j = 0; j < n; j++) begin
         pulse();
         if (!m_latched && m_k < m_bits.size()) begin
            m_k++;
            if (m_k == m_bits.size()) m_exp_done++;
         end
         m_check(tag);
      end
      chk({tag, "_done"}, done_cnt_a - d0, m_exp_done);
   endtask

   task automatic m_frame(input int n, input bit scramble, input string tag);
      set_ps(1'b1);
      m_build();
      m_k = 0;
      m_latched = 1'b1;
      m_check(tag);
      set_ps(1'b0);
      m_latched = 1'b0;
      m_check(tag);
      if (scramble) begin
         i_a  = $urandom;
         pp_a = 2'($urandom_range(0, 3));
      end
      m_run(n, tag);
   endtask

   typedef struct {
      logic [31:0] iw;
      logic [1:0]  pp;
      int          nclk;
      logic        din;
      logic        e_dat;
      logic        e_busy;
      int          e_done;
   } vec_t;

   vec_t vt[14];

   initial begin
      logic [15:0] pat;
      int d0;

      vt[0]  = '{32'hFFFF_8001, 2'b10,  0, 1'b0, 1'b1, 1'b1, 0};
      vt[1]  = '{32'hFFFF_8001, 2'b10,  1, 1'b0, 1'b0, 1'b1, 0};
      vt[2]  = '{32'hFFFF_8001, 2'b10, 15, 1'b0, 1'b1, 1'b1, 0};
      vt[3]  = '{32'hFFFF_8001, 2'b10, 16, 1'b1, 1'b1, 1'b0, 1};
      vt[4]  = '{32'hFFFF_8001, 2'b11, 15, 1'b0, 1'b1, 1'b1, 0};
      vt[5]  = '{32'hFFFF_8001, 2'b11, 16, 1'b0, 1'b1, 1'b1, 0};
      vt[6]  = '{32'hFFFF_8001, 2'b11, 17, 1'b0, 1'b0, 1'b1, 0};
      vt[7]  = '{32'hFFFF_8001, 2'b11, 32, 1'b0, 1'b0, 1'b0, 1};
      vt[8]  = '{32'hFFFF_8001, 2'b11, 32, 1'b1, 1'b1, 1'b0, 1};
      vt[9]  = '{32'hFFFF_8001, 2'b00,  0, 1'b1, 1'b1, 1'b0, 0};
      vt[10] = '{32'hFFFF_8001, 2'b00,  3, 1'b0, 1'b0, 1'b0, 0};
      vt[11] = '{32'hA5A5_0000, 2'b01,  2, 1'b0, 1'b1, 1'b1, 0};
      vt[12] = '{32'hA5A5_0000, 2'b01,  3, 1'b0, 1'b0, 1'b1, 0};
      vt[13] = '{32'h1234_A5A5, 2'b11, 16, 1'b0, 1'b1, 1'b1, 0};

      // Reset state
      tick(3);
      chk("rst_dat_a", dat_a, 0);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_done_a", done_a, 0);
      chk("rst_dat_b", dat_b, 0);
      chk("rst_busy_b", busy_b, 0);
      chk("rst_done_b", done_b, 0);
      rst_n = 1'b1;
      tick(4);

      foreach (vt[k]) begin
         i_a  = vt[k].iw;
         pp_a = vt[k].pp;
         din  = vt[k].din;
         d0   = done_cnt_a;
         set_ps(1'b1);
         set_ps(1'b0);
         repeat (vt[k].nclk) pulse();
         chk($sformatf("vec%0d_dat", k), dat_a, vt[k].e_dat);
         chk($sformatf("vec%0d_busy", k), busy_a, vt[k].e_busy);
         chk($sformatf("vec%0d_done", k), done_cnt_a - d0, vt[k].e_done);
      end

      // Single pad C006, clk pulse while latched must be ignored
      i_b  = 16'hC006;
      pp_b = 1'b1;
      din  = 1'b0;
      pat  = 16'hC006;
      set_ps(1'b1);
      pulse();
      set_ps(1'b0);
      d0 = done_cnt_b;
      for (int j = 0; j < 32; j++) begin
         chk($sformatf("b_bit%0d", j), dat_b, (j < 16) ? pat[15-j] : 1'b0);
         if (j == 15) begin
            chk("b_busy15", busy_b, 1);
            chk("b_done15", done_cnt_b - d0, 0);
         end
         if (j == 16) begin
            chk("b_busy16", busy_b, 0);
            chk("b_done16", done_cnt_b - d0, 1);
         end
         if (j == 20) din = 1'b1;
         pulse();
      end
      chk("b_done_once", done_cnt_b - d0, 1);
      din = 1'b0;

      // Simultaneous ps/clk edges
      i_a  = 32'hFFFF_8001;
      pp_a = 2'b10;
      set_ps(1'b1);
      set_ps(1'b0);
      repeat (3) pulse();
      chk("sim_pre_dat", dat_a, 0);
      con_ps  = 1'b1;
      con_clk = 1'b1;
      tick(8);
      chk("sim_rise_dat", dat_a, 1);
      chk("sim_rise_busy", busy_a, 0);
      con_clk = 1'b0;
      tick(8);
      con_ps  = 1'b0;
      con_clk = 1'b1;
      tick(8);
      chk("sim_fall_dat", dat_a, 1);
      chk("sim_fall_busy", busy_a, 1);
      con_clk = 1'b0;
      tick(8);
      con_clk = 1'b1;
      tick(8);
      chk("sim_shift1_dat", dat_a, 0);
      con_clk = 1'b0;
      tick(8);

      // Pin-to-dat latency
      set_ps(1'b1);
      set_ps(1'b0);
      chk("lat_start", dat_a, 1);
      con_clk = 1'b1;
      repeat (3) @(posedge sysclk);
      #1 chk("lat_clk_early", dat_a, 1);
      @(posedge sysclk);
      #1 chk("lat_clk", dat_a, 0);
      tick(1);
      con_clk = 1'b0;
      tick(8);
      repeat (15) pulse();
      chk("lat_tail0", dat_a, 0);
      din = 1'b1;
      repeat (4) @(posedge sysclk);
      #1 chk("lat_din", dat_a, 1);
      tick(1);
      din = 1'b0;
      tick(4);

      // Mid-frame re-latch
      i_a  = 32'hFFFF_8001;
      pp_a = 2'b11;
      set_ps(1'b1);
      set_ps(1'b0);
      repeat (5) pulse();
      chk("relatch_pre", dat_a, 1);
      i_a = 32'h7FFF_0F0F;
      set_ps(1'b1);
      chk("relatch_dat", dat_a, 0);
      chk("relatch_busy", busy_a, 0);
      set_ps(1'b0);
      m_build();
      m_k = 0;
      m_latched = 1'b0;
      m_check("relatch0");
      m_run(34, "relatch");

      // Asynchronous reset mid-SHIFT
      i_a  = 32'hFFFF_FFFF;
      pp_a = 2'b11;
      set_ps(1'b1);
      set_ps(1'b0);
      repeat (3) pulse();
      chk("mid_dat", dat_a, 1);
      chk("mid_busy", busy_a, 1);
      @(posedge sysclk);
      #7 rst_n = 1'b0;
      #1;
      chk("arst_dat", dat_a, 0);
      chk("arst_busy", busy_a, 0);
      chk("arst_done", done_a, 0);
      tick(2);
      rst_n = 1'b1;
      tick(4);
      i_a  = 32'h1357_9BDF;
      pp_a = 2'b11;
      m_frame(33, 1'b0, "postrst");

      // Randomized frames, inputs scrambled mid-frame
      for (int f = 0; f < 20; f++) begin
         i_a  = $urandom;
         pp_a = 2'($urandom_range(0, 3));
         din  = 1'($urandom_range(0, 1));
         m_frame($urandom_range(0, 36), 1'b1, $sformatf("rnd%0d", f));
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
